// File: rtl/seg7_capture_decoder_if.sv
// Segment bus in, recovered digit/status out, between the pin side and the digit consumer.
interface seg7_capture_decoder_if;
    logic [6:0] seg_in;
    logic       blank_in;
    logic [3:0] digit;
    logic       digit_valid;
    logic       blank;
    logic       seg_err;
    logic [3:0] err_count;
    logic [7:0] history;

    modport master (
        output seg_in, blank_in,
        input  digit, digit_valid, blank, seg_err, err_count, history
    );

    modport slave (
        input  seg_in, blank_in,
        output digit, digit_valid, blank, seg_err, err_count, history
    );
endinterface

// File: rtl/seg7_capture_decoder.sv
// Recovers hex digits from a 7-segment bus: synchronize, wait for a stable pattern, classify once.
// state  | meaning
// SETTLE | pattern changed recently, counting matching samples
// HELD   | current pattern already captured, waiting for next change
module seg7_capture_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    seg7_capture_decoder_if.slave bus
);

    typedef enum logic [0:0] {SETTLE, HELD} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       s1, s2, s_prev;
    logic             same, terminal, capture;
    logic             legal, is_blank;
    logic [3:0]       value;

    logic [3:0]       digit_q;
    logic             digit_valid_q;
    logic             blank_q;
    logic             seg_err_q;
    logic [3:0]       err_count_q;
    logic [7:0]       history_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= '0;
            s2     <= '0;
            s_prev <= '0;
        end else begin
            s1     <= {bus.blank_in, bus.seg_in};
            s2     <= s1;
            s_prev <= s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign same     = (s2 == s_prev);
    assign terminal = (cnt == CNT_W'(STABLE_CYCLES - 1));

    // A change restarts the count from any state, so each stable period captures exactly once.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        if (!same) begin
            state_nxt = SETTLE;
            cnt_nxt   = '0;
        end else if (state == SETTLE) begin
            if (terminal) begin
                capture   = 1'b1;
                state_nxt = HELD;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        legal = 1'b1;
        value = 4'h0;
        case (s2[6:0])
            7'h3F: value = 4'h0;
            7'h06: value = 4'h1;
            7'h5B: value = 4'h2;
            7'h4F: value = 4'h3;
            7'h66: value = 4'h4;
            7'h6D: value = 4'h5;
            7'h7D: value = 4'h6;
            7'h07: value = 4'h7;
            7'h7F: value = 4'h8;
            7'h6F: value = 4'h9;
            7'h77: value = 4'hA;
            7'h7C: value = 4'hB;
            7'h39: value = 4'hC;
            7'h5E: value = 4'hD;
            7'h79: value = 4'hE;
            7'h71: value = 4'hF;
            default: legal = 1'b0;
        endcase
    end

    assign is_blank = s2[7] || (s2[6:0] == 7'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q       <= 4'h0;
            digit_valid_q <= 1'b0;
            blank_q       <= 1'b1;
            seg_err_q     <= 1'b0;
            err_count_q   <= 4'h0;
            history_q     <= 8'h00;
        end else begin
            digit_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            if (capture) begin
                if (is_blank) begin
                    blank_q <= 1'b1;
                end else if (legal) begin
                    blank_q       <= 1'b0;
                    digit_q       <= value;
                    history_q     <= {history_q[3:0], value};
                    digit_valid_q <= 1'b1;
                end else begin
                    seg_err_q <= 1'b1;
                    if (err_count_q != 4'hF) begin
                        err_count_q <= err_count_q + 4'h1;
                    end
                end
            end
        end
    end

    assign bus.digit       = digit_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.blank       = blank_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.err_count   = err_count_q;
    assign bus.history     = history_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder; expected pulses queued at drive time, checked by a monitor.
module tb_seg7_capture_decoder;

    localparam int STABLE = 4;
    localparam int LAT    = STABLE + 3;

    typedef struct {
        bit         is_err;
        logic [3:0] digit;
        logic [7:0] hist;
        logic [3:0] errc;
        logic       blank;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    logic [3:0] exp_digit;
    logic [7:0] exp_hist;
    logic [3:0] exp_err;
    logic       exp_blank;

    seg7_capture_decoder_if bus ();

    seg7_capture_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic push_valid(input logic [3:0] d);
        exp_t e;
        exp_hist  = {exp_hist[3:0], d};
        exp_digit = d;
        exp_blank = 1'b0;
        e = '{is_err: 1'b0, digit: d, hist: exp_hist, errc: exp_err, blank: 1'b0, cyc: cyc + LAT};
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        exp_err = (exp_err == 4'hF) ? 4'hF : exp_err + 4'h1;
        e = '{is_err: 1'b1, digit: exp_digit, hist: exp_hist, errc: exp_err, blank: exp_blank, cyc: cyc + LAT};
        sb.push_back(e);
    endtask

    task automatic drive(input logic [6:0] seg, input logic blk);
        @(negedge clk);
        bus.seg_in   = seg;
        bus.blank_in = blk;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.digit_valid || bus.seg_err) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b digit=%0h at cycle %0d, expected no pulse",
                         bus.digit_valid, bus.seg_err, bus.digit, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind_err", int'(bus.seg_err), int'(e.is_err));
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_digit", int'(bus.digit), int'(e.digit));
                check("pulse_history", int'(bus.history), int'(e.hist));
                check("pulse_err_count", int'(bus.err_count), int'(e.errc));
                check("pulse_blank", int'(bus.blank), int'(e.blank));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        exp_digit    = 4'h0;
        exp_hist     = 8'h00;
        exp_err      = 4'h0;
        exp_blank    = 1'b1;
        rst_n        = 1'b0;
        bus.seg_in   = 7'h00;
        bus.blank_in = 1'b0;

        // 1: idle blank bus after reset
        idle(3);
        rst_n = 1'b1;
        idle(20);
        check("t1_blank", int'(bus.blank), 1);
        check("t1_digit", int'(bus.digit), 0);
        check("t1_err_count", int'(bus.err_count), 0);
        check("t1_history", int'(bus.history), 0);

        // 2: two legal digits
        drive(7'h4F, 1'b0); push_valid(4'h3); idle(10);
        check("t2_blank_low", int'(bus.blank), 0);
        drive(7'h66, 1'b0); push_valid(4'h4); idle(10);
        check("t2_history", int'(bus.history), 8'h34);

        // 3: short glitch must not capture
        drive(7'h06, 1'b0); push_valid(4'h1); idle(10);
        drive(7'h7F, 1'b0);
        idle(2);
        drive(7'h06, 1'b0); push_valid(4'h1); idle(12);
        check("t3_digit", int'(bus.digit), 1);

        // 4: illegal/legal alternation, err_count saturates
        drive(7'h55, 1'b0); push_err(); idle(10);
        for (int i = 0; i < 17; i++) begin
            drive(7'h3F, 1'b0); push_valid(4'h0); idle(10);
            drive(7'h55, 1'b0); push_err(); idle(10);
        end
        check("t4_err_sat", int'(bus.err_count), 15);
        check("t4_digit", int'(bus.digit), 0);

        // 5: blank flag overrides a legal pattern
        drive(7'h6D, 1'b1); exp_blank = 1'b1; idle(10);
        check("t5_blank_high", int'(bus.blank), 1);
        check("t5_digit_kept", int'(bus.digit), 0);
        drive(7'h6D, 1'b0); push_valid(4'h5); idle(10);
        check("t5_digit", int'(bus.digit), 5);

        // 6: reset in the middle of a count
        drive(7'h07, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_digit", int'(bus.digit), 0);
        check("t6_rst_blank", int'(bus.blank), 1);
        check("t6_rst_err_count", int'(bus.err_count), 0);
        check("t6_rst_history", int'(bus.history), 0);
        exp_digit = 4'h0;
        exp_hist  = 8'h00;
        exp_err   = 4'h0;
        exp_blank = 1'b1;
        idle(2);
        rst_n = 1'b1;
        push_valid(4'h7);
        idle(12);
        check("t6_digit", int'(bus.digit), 7);
        check("t6_history", int'(bus.history), 8'h07);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
